// File: rtl/flash_arbiter.sv
// Two-port read arbiter sharing one synchronous program flash between the
// instruction-fetch port (I) and the data-side port (D), with per-port hold registers.
module flash_arbiter #(
    parameter int FLASH_WIDTH  = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic [FLASH_WIDTH-1:0] i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [15:0]            i_rdata,
    input  logic                   d_req,
    input  logic [FLASH_WIDTH-1:0] d_addr,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [15:0]            d_rdata,
    output logic                   mem_ce,
    output logic [FLASH_WIDTH-1:0] mem_a,
    input  logic [15:0]            mem_d
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t      owner;
    owner_t      owner_next;
    logic [3:0]  d_wait;
    logic [3:0]  d_wait_next;
    logic [15:0] i_hold;
    logic [15:0] d_hold;
    logic        starved;

    assign starved = (d_wait == LIMIT);

    // Grant decision: a starved D beats I, otherwise I has fixed priority.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (d_req && starved) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    // Flash port drive and next in-flight owner tag.
    always_comb begin
        mem_ce     = 1'b0;
        mem_a      = '0;
        owner_next = OWN_NONE;
        if (i_gnt) begin
            mem_ce     = 1'b1;
            mem_a      = i_addr;
            owner_next = OWN_I;
        end else if (d_gnt) begin
            mem_ce     = 1'b1;
            mem_a      = d_addr;
            owner_next = OWN_D;
        end else begin
            mem_ce     = 1'b0;
            mem_a      = '0;
            owner_next = OWN_NONE;
        end
    end

    // Starvation count: saturates while D waits, clears on grant or drop.
    always_comb begin
        d_wait_next = 4'd0;
        if (d_req && !d_gnt) begin
            if (starved) begin
                d_wait_next = LIMIT;
            end else begin
                d_wait_next = d_wait + 4'd1;
            end
        end else begin
            d_wait_next = 4'd0;
        end
    end

    // State register: owner tag, starvation count, and hold-register capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner  <= OWN_NONE;
            d_wait <= 4'd0;
            i_hold <= 16'd0;
            d_hold <= 16'd0;
        end else begin
            owner  <= owner_next;
            d_wait <= d_wait_next;
            if (i_rvalid) begin
                i_hold <= mem_d;
            end
            if (d_rvalid) begin
                d_hold <= mem_d;
            end
        end
    end

    // Read-return outputs; reset masks a read that was in flight.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = 16'd0;
        d_rdata  = 16'd0;
        if (rst) begin
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
            i_rdata  = 16'd0;
            d_rdata  = 16'd0;
        end else begin
            i_rvalid = (owner == OWN_I);
            d_rvalid = (owner == OWN_D);
            i_rdata  = i_rvalid ? mem_d : i_hold;
            d_rdata  = d_rvalid ? mem_d : d_hold;
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Randomized self-checking bench for flash_arbiter against a cycle-level
// behavioural model of the arbitration rules and a flash memory array.
module tb_flash_arbiter;

    localparam int AW    = 10;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [15:0]   i_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [15:0]   d_rdata;
    logic          mem_ce;
    logic [AW-1:0] mem_a;
    logic [15:0]   mem_d = 16'd0;

    logic [15:0] flash [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    // model state
    int          m_wait = 0;
    int          m_prev = 0;     // 0 none, 1 I, 2 D
    int          m_prev_addr = 0;
    logic [15:0] m_ihold = 16'd0;
    logic [15:0] m_dhold = 16'd0;
    int          m_last_grant = 0;

    flash_arbiter #(.FLASH_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_a(mem_a), .mem_d(mem_d)
    );

    always #5 clk = ~clk;

    // flash: registered read data valid the cycle after mem_ce
    always @(posedge clk) begin
        if (mem_ce) mem_d <= flash[mem_a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic [AW-1:0] da);
        int          g;
        logic        e_iv, e_dv;
        logic [15:0] e_ir, e_dr, rd;
        @(negedge clk);
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
        #1;
        if (r) g = 0;
        else if (dr && m_wait == LIMIT) g = 2;
        else if (ir) g = 1;
        else if (dr) g = 2;
        else g = 0;
        rd   = flash[m_prev_addr];
        e_iv = !r && m_prev == 1;
        e_dv = !r && m_prev == 2;
        e_ir = r ? 16'd0 : (e_iv ? rd : m_ihold);
        e_dr = r ? 16'd0 : (e_dv ? rd : m_dhold);
        check("i_gnt",    32'(i_gnt),    32'(g == 1));
        check("d_gnt",    32'(d_gnt),    32'(g == 2));
        check("mem_ce",   32'(mem_ce),   32'(g != 0));
        check("mem_a",    32'(mem_a),    (g == 1) ? 32'(ia) : (g == 2) ? 32'(da) : 32'd0);
        check("i_rvalid", 32'(i_rvalid), 32'(e_iv));
        check("d_rvalid", 32'(d_rvalid), 32'(e_dv));
        check("i_rdata",  32'(i_rdata),  32'(e_ir));
        check("d_rdata",  32'(d_rdata),  32'(e_dr));
        if (r) begin
            m_prev = 0; m_wait = 0; m_ihold = 16'd0; m_dhold = 16'd0;
        end else begin
            if (e_iv) m_ihold = rd;
            if (e_dv) m_dhold = rd;
            m_wait = (dr && g != 2) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
            m_prev = g;
            m_prev_addr = (g == 1) ? int'(ia) : (g == 2) ? int'(da) : 0;
        end
        m_last_grant = g;
    endtask

    initial begin
        int          drv;
        logic        ir, dr, r;
        logic [AW-1:0] ia, da;

        for (int k = 0; k < (1 << AW); k++) flash[k] = 16'($urandom);
        flash[10'h005] = 16'hBEEF;
        flash[10'h010] = 16'h1234;
        flash[10'h011] = 16'h5678;

        // reset with both requesters active, then release
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 10'h005, 1'b1, 10'h010);
        cycle(1'b0, 1'b1, 10'h005, 1'b1, 10'h010);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);

        // single I read and hold
        cycle(1'b0, 1'b1, 10'h005, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        check("i_hold_beef", 32'(i_rdata), 32'h0000BEEF);

        // continuous contention: D gets 2 of 12 slots
        drv = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b1, 10'h005, 1'b1, 10'h010);
            if (d_rvalid) drv++;
        end
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        if (d_rvalid) drv++;
        check("contention_d_reads", 32'(drv), 32'd2);

        // interleave: D then I, D data must stay put
        cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h010);
        cycle(1'b0, 1'b1, 10'h011, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        check("interleave_d", 32'(d_rdata), 32'h00001234);
        check("interleave_i", 32'(i_rdata), 32'h00005678);

        // reset while a D read is in flight
        cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h010);
        cycle(1'b1, 1'b0, 10'h000, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        check("midreset_d_rdata", 32'(d_rdata), 32'd0);

        // back-to-back D reads across the address wrap
        cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h3FE);
        cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF);
        cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
        cycle(1'b0, 1'b0, 10'h000, 1'b0, 10'h000);

        // random traffic; a waiting requester keeps req and addr stable
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!(ir && m_last_grant != 1) || m_last_grant == 0 && !ir) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = AW'($urandom);
            end
            if (!(dr && m_last_grant != 2)) begin
                dr = ($urandom_range(0, 2) == 0);
                da = AW'($urandom);
            end
            if (r || $urandom_range(0, 19) == 0) begin
                ir = ($urandom_range(0, 1) != 0);
                dr = ($urandom_range(0, 1) != 0);
            end
            cycle(r, ir, ia, dr, da);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
